mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the single-cycle datapath.
- Takes the effective address (ALU result) and store data from the datapath, and drives a word-wide data RAM that has wait states.
- Returns aligned, sign- or zero-extended load data to the register write-back mux.
- Stalls the core until the memory access completes, and reports misaligned, illegal or timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 16, maximum WAIT cycles without mem_ready before the access is aborted (range 1..255).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  datapath presents a load/store this cycle
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte effective address
req_wdata  input  32  store data (rs2), LSB-aligned
stall  output  1  hold PC and register file this cycle
rsp_valid  output  1  one-cycle pulse: access completed
rsp_rdata  output  32  extended load data, valid with rsp_valid (0 for stores)
err_valid  output  1  one-cycle pulse: access aborted
err_code  output  2  01 misaligned, 10 timeout, 11 illegal funct3; 00 when err_valid=0
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  write strobe
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_be  output  4  byte enables
mem_ready  input  1  memory accepts/completes the request this cycle
mem_rdata  input  32  read word, valid when mem_ready=1 on a load

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE; timeout counter and all captured registers clear.
  - Every output is 0, including stall, mem_req and err_code.
  - Any in-flight memory access is abandoned; mem_ready received after reset is ignored.
- States: IDLE, WAIT, RESP, ERR.
- IDLE:
  - When req_valid=1, check the request in priority order: illegal funct3 > misaligned > valid.
  - Illegal funct3: loads 011, 110, 111; stores anything above 010. Go to ERR with code 11.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0. Go to ERR with code 01.
  - Otherwise register addr, we, funct3 and wdata, then go to WAIT.
  - No memory request is issued on any error path.
- WAIT:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata are driven from the registered request and held stable.
  - mem_ready=1: go to RESP. On a load, capture the extracted and extended rdata.
  - Otherwise increment the counter. When counter = TIMEOUT_CYCLES−1 and mem_ready=0, drop mem_req and go to ERR with code 10.
- RESP: rsp_valid=1 and stall=0 for one cycle, then IDLE unconditionally. req_valid in this cycle is ignored.
- ERR: err_valid=1 with the latched err_code and stall=0 for one cycle, then IDLE.
- stall = (IDLE & req_valid) | WAIT. The datapath keeps its request stable while stall=1.
- Latency: accept to rsp_valid is 2 cycles with zero wait states, plus one cycle per wait state. Errors detected in IDLE are reported 1 cycle after accept.
- Byte enables:
  - SB: mem_be = 0001 << addr[1:0]; wdata byte replicated to all 4 lanes.
  - SH: mem_be = 0011 or 1100 by addr[1]; halfword replicated.
  - SW: mem_be = 1111.
  - Loads: mem_be = 1111, mem_we = 0.
- Load extraction:
  - Select the byte lane by addr[1:0], or the half lane by addr[1].
  - B and H sign-extend from bit 7 / bit 15; BU and HU zero-extend; W passes through.
- The timeout counter clears on every entry to WAIT.
- mem_ready outside WAIT is ignored.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, mem_ready high on the first WAIT cycle → mem_addr 0x100, be 1111, wdata 0xDEADBEEF; stall high 2 cycles; rsp_valid on cycle 2.
- LB addr 0x103, mem_rdata 0x80FF_1234 after 3 wait states → rsp_rdata 0xFFFFFF80. Repeat as LBU → 0x00000080. Stall lasts 5 cycles.
- SH addr 0x202, wdata 0x0000ABCD → be 1100, mem_wdata 0xABCDABCD. LHU addr 0x202 with rdata 0xABCD0000 → 0x0000ABCD.
- Error paths, none of which raise mem_req:
  - LW addr 0x101 → err_valid, err_code 01.
  - funct3 011 load → err_code 11.
  - Store with funct3 100 → err_code 11.
- mem_ready held low → after TIMEOUT_CYCLES=16 WAIT cycles: mem_req drops, err_code 10, then IDLE. A following LW addr 0x0 completes normally.
- rst asserted low during WAIT, with a late mem_ready pulse after release → all outputs 0 immediately; the late mem_ready produces no rsp_valid.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the single-cycle datapath and a word-wide data RAM with wait states.
// Aligns store lanes, extends load data, stalls the core and reports aborted accesses.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10,
        S_ERR  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       err_code_q, err_code_d;

    logic        illegal_c;
    logic        misalign_c;
    logic [7:0]  lane_byte_c;
    logic [15:0] lane_half_c;
    logic [31:0] load_ext_c;
    logic [3:0]  store_be_c;
    logic [31:0] store_wdata_c;

    // Request decode: funct3 legality depends on direction; alignment by access width
    always_comb begin
        illegal_c = 1'b0;
        if (req_we) begin
            illegal_c = (req_funct3 > 3'b010);
        end else begin
            illegal_c = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Load lane selection and extension from the registered request
    always_comb begin
        lane_byte_c = 8'h00;
        case (addr_q[1:0])
            2'b00:   lane_byte_c = mem_rdata[7:0];
            2'b01:   lane_byte_c = mem_rdata[15:8];
            2'b10:   lane_byte_c = mem_rdata[23:16];
            default: lane_byte_c = mem_rdata[31:24];
        endcase
        lane_half_c = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext_c = {{24{lane_byte_c[7]}}, lane_byte_c};
            3'b001:  load_ext_c = {{16{lane_half_c[15]}}, lane_half_c};
            3'b100:  load_ext_c = {24'h000000, lane_byte_c};
            3'b101:  load_ext_c = {16'h0000, lane_half_c};
            default: load_ext_c = mem_rdata;
        endcase
    end

    // Store byte enables and lane replication; loads always read the full word
    always_comb begin
        store_be_c    = 4'b1111;
        store_wdata_c = wdata_q;
        if (we_q) begin
            case (funct3_q[1:0])
                2'b00: begin
                    store_be_c    = 4'b0001 << addr_q[1:0];
                    store_wdata_c = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    store_be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
                    store_wdata_c = {2{wdata_q[15:0]}};
                end
                default: begin
                    store_be_c    = 4'b1111;
                    store_wdata_c = wdata_q;
                end
            endcase
        end
    end

    // Next-state and captured-register logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (illegal_c) begin
                        err_code_d = ERR_ILLEGAL;
                        state_d    = S_ERR;
                    end else if (misalign_c) begin
                        err_code_d = ERR_MISALIGN;
                        state_d    = S_ERR;
                    end else begin
                        addr_d   = req_addr;
                        we_d     = req_we;
                        funct3_d = req_funct3;
                        wdata_d  = req_wdata;
                        cnt_d    = '0;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    rdata_d = we_q ? 32'h0 : load_ext_c;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                rdata_d = 32'h0;
                state_d = S_IDLE;
            end
            default: begin
                err_code_d = ERR_NONE;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= 32'h0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_code_q <= err_code_d;
        end
    end

    // Outputs decode from the state register; stall also sees the live request in IDLE
    always_comb begin
        stall     = rst && (((state_q == S_IDLE) && req_valid) || (state_q == S_WAIT));
        rsp_valid = (state_q == S_RESP);
        rsp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;
        err_valid = (state_q == S_ERR);
        err_code  = (state_q == S_ERR) ? err_code_q : ERR_NONE;
        mem_req   = (state_q == S_WAIT);
        mem_we    = (state_q == S_WAIT) && we_q;
        mem_addr  = (state_q == S_WAIT) ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_be    = (state_q == S_WAIT) ? store_be_c : 4'b0000;
        mem_wdata = (state_q == S_WAIT) ? store_wdata_c : 32'h0;
    end

endmodule
